// File: rtl/pdes_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pdes_sched_ctrl
//  Purpose  : PDES scheduler control. Seeds the initial events, arbitrates
//             core-generated events into an external priority queue,
//             dispatches queue-head events to idle cores, tracks GVT and
//             terminates on end time or drain.
//  Options  : PDES_SCHED_STATS_EN adds stat_enq/stat_deq/stat_maxq outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module pdes_sched_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int TW        = 16,
  parameter int LPW       = 3,
  parameter int NUM_INIT  = 4,
  parameter int SIM_END   = 1000,
  parameter int CNTW      = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [TW-1:0]                     gvt,
  input  logic [NUM_CORES-1:0]              core_new_vld,
  input  logic [NUM_CORES*(LPW+TW)-1:0]     core_new_data,
  output logic [NUM_CORES-1:0]              core_new_ack,
  input  logic [NUM_CORES-1:0]              core_ready,
  input  logic [NUM_CORES-1:0]              core_done,
  output logic [NUM_CORES-1:0]              core_evt_vld,
  output logic [LPW+TW-1:0]                 core_evt_data,
  output logic                              q_enq,
  output logic [LPW+TW-1:0]                 q_enq_data,
  output logic                              q_deq,
  input  logic [LPW+TW-1:0]                 q_head,
  input  logic [CNTW-1:0]                   q_count,
  input  logic                              q_full
`ifdef PDES_SCHED_STATS_EN
  ,
  output logic [31:0]                       stat_enq,
  output logic [31:0]                       stat_deq,
  output logic [CNTW-1:0]                   stat_maxq
`endif
);

  localparam int c_ew  = LPW + TW;
  localparam int c_pw  = $clog2(NUM_CORES);
  localparam int c_bw  = $clog2(NUM_CORES * c_ew);
  localparam int c_icw = (NUM_INIT < 2) ? 1 : $clog2(NUM_INIT + 1);
  localparam logic [c_icw-1:0] c_init_last = c_icw'(NUM_INIT - 1);
  localparam logic [TW:0]      c_sim_end   = (TW+1)'(SIM_END);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t               r_state, w_next;
  logic [c_icw-1:0]     r_init_cnt;
  logic [LPW-1:0]       w_init_lp;
  logic [c_pw-1:0]      r_eptr, r_dptr, w_esel, w_dsel;
  logic [c_bw-1:0]      w_ebase;
  logic [NUM_CORES-1:0] r_act;
  logic [TW-1:0]        r_loc [NUM_CORES];
  logic [TW-1:0]        w_cand;
  logic                 w_has, w_drained, r_drain_seen, w_gvt_end, w_start;

  // First requester at or after ptr, scanning circularly.
  function automatic logic [c_pw-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                              input logic [c_pw-1:0]      ptr);
    logic [c_pw-1:0] sel;
    int              idx;
    sel = ptr;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_CORES;
      if (req[c_pw'(idx)]) sel = c_pw'(idx);
    end
    return sel;
  endfunction

  function automatic logic [c_pw-1:0] rr_next(input logic [c_pw-1:0] sel);
    return (sel == c_pw'(NUM_CORES - 1)) ? '0 : sel + c_pw'(1);
  endfunction

  assign w_start   = (r_state == S_IDLE) && start;
  assign w_esel    = rr_pick(core_new_vld, r_eptr);
  assign w_dsel    = rr_pick(core_ready, r_dptr);
  assign w_ebase   = c_bw'(w_esel) * c_bw'(c_ew);
  assign w_drained = (q_count == '0) && (r_act == '0) && (core_new_vld == '0);
  assign w_gvt_end = {1'b0, gvt} > c_sim_end;
  assign busy      = (r_state == S_INIT) || (r_state == S_RUN);
  assign done      = (r_state == S_FIN);
  assign core_evt_data = q_head;

  // Seed LP id is the push index modulo 2^LPW.
  generate
    if (c_icw >= LPW) begin : g_lp_trunc
      assign w_init_lp = r_init_cnt[LPW-1:0];
    end else begin : g_lp_ext
      assign w_init_lp = {{(LPW - c_icw){1'b0}}, r_init_cnt};
    end
  endgenerate

  // GVT candidate: minimum over active cores' local times and the queue head.
  always_comb begin
    w_cand = '1;
    w_has  = 1'b0;
    if (q_count != '0) begin
      w_cand = q_head[TW-1:0];
      w_has  = 1'b1;
    end
    for (int g = 0; g < NUM_CORES; g++) begin
      if (r_act[g]) begin
        w_has = 1'b1;
        if (r_loc[g] < w_cand) w_cand = r_loc[g];
      end
    end
  end

  // Next state and queue/core strobes; enqueue takes priority over dispatch.
  always_comb begin
    w_next       = r_state;
    q_enq        = 1'b0;
    q_enq_data   = '0;
    q_deq        = 1'b0;
    core_new_ack = '0;
    core_evt_vld = '0;
    case (r_state)
      S_IDLE: if (start) w_next = S_INIT;
      S_INIT: begin
        if (!q_full) begin
          q_enq      = 1'b1;
          q_enq_data = {w_init_lp, {TW{1'b0}}};
          if (r_init_cnt == c_init_last) w_next = S_RUN;
        end
      end
      S_RUN: begin
        if ((core_new_vld != '0) && !q_full) begin
          core_new_ack[w_esel] = 1'b1;
          q_enq                = 1'b1;
          q_enq_data           = core_new_data[w_ebase +: c_ew];
        end else if ((q_count != '0) && (core_ready != '0)) begin
          q_deq                = 1'b1;
          core_evt_vld[w_dsel] = 1'b1;
        end
        if (w_gvt_end || (w_drained && r_drain_seen)) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus one-cycle memory of the drained condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_drain_seen <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_drain_seen <= (r_state == S_RUN) && w_drained;
    end
  end

  // Count seed pushes during INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_init_cnt <= '0;
    else if (w_start)                     r_init_cnt <= '0;
    else if ((r_state == S_INIT) && q_enq) r_init_cnt <= r_init_cnt + c_icw'(1);
  end

  // Round-robin pointers move to the core after the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eptr <= '0;
      r_dptr <= '0;
    end else begin
      if (core_new_ack != '0) r_eptr <= rr_next(w_esel);
      if (q_deq)              r_dptr <= rr_next(w_dsel);
    end
  end

  // Core activity and local time; a dispatch overrides a same-cycle done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act <= '0;
      for (int g = 0; g < NUM_CORES; g++) r_loc[g] <= '0;
    end else if (w_start) begin
      r_act <= '0;
    end else begin
      r_act <= (r_act & ~core_done) | core_evt_vld;
      if (q_deq) r_loc[w_dsel] <= q_head[TW-1:0];
    end
  end

  // GVT is monotonic: only ever raised to a larger candidate while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       gvt <= '0;
    else if (w_start) gvt <= '0;
    else if ((r_state == S_RUN) && w_has && (w_cand > gvt)) gvt <= w_cand;
  end

`ifdef PDES_SCHED_STATS_EN
  // Saturating RUN-state push/pop counters and peak queue occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_enq  <= '0;
      stat_deq  <= '0;
      stat_maxq <= '0;
    end else if (w_start) begin
      stat_enq  <= '0;
      stat_deq  <= '0;
      stat_maxq <= '0;
    end else begin
      if ((core_new_ack != '0) && (stat_enq != '1)) stat_enq <= stat_enq + 32'd1;
      if (q_deq && (stat_deq != '1))                stat_deq <= stat_deq + 32'd1;
      if (busy && (q_count > stat_maxq))            stat_maxq <= q_count;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pdes_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pdes_sched_ctrl
//  Purpose  : Randomised scoreboard bench for pdes_sched_ctrl with a
//             behavioural priority queue and core environment.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pdes_sched_ctrl;
  localparam int N    = 4;
  localparam int TW   = 16;
  localparam int LPW  = 3;
  localparam int NI   = 4;
  localparam int SE   = 100;
  localparam int CNTW = 5;
  localparam int EW   = LPW + TW;
  localparam int CAP  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, busy, done;
  logic [TW-1:0]     gvt;
  logic [N-1:0]      core_new_vld, core_new_ack, core_ready, core_done, core_evt_vld;
  logic [N*EW-1:0]   core_new_data;
  logic [EW-1:0]     core_evt_data, q_enq_data, q_head;
  logic              q_enq, q_deq, q_full;
  logic [CNTW-1:0]   q_count;
`ifdef PDES_SCHED_STATS_EN
  logic [31:0]       stat_enq, stat_deq;
  logic [CNTW-1:0]   stat_maxq;
`endif

  pdes_sched_ctrl #(.NUM_CORES(N), .TW(TW), .LPW(LPW), .NUM_INIT(NI),
                    .SIM_END(SE), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .gvt(gvt),
    .core_new_vld(core_new_vld), .core_new_data(core_new_data),
    .core_new_ack(core_new_ack), .core_ready(core_ready), .core_done(core_done),
    .core_evt_vld(core_evt_vld), .core_evt_data(core_evt_data),
    .q_enq(q_enq), .q_enq_data(q_enq_data), .q_deq(q_deq), .q_head(q_head),
    .q_count(q_count), .q_full(q_full)
`ifdef PDES_SCHED_STATS_EN
    , .stat_enq(stat_enq), .stat_deq(stat_deq), .stat_maxq(stat_maxq)
`endif
  );

  typedef struct packed {
    logic          enq;
    logic [EW-1:0] enq_data;
    logic [N-1:0]  ack;
    logic          deq;
    logic [N-1:0]  evt;
    logic [EW-1:0] evt_data;
    logic          busy;
    logic          done;
    logic [TW-1:0] gvt;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model: phase 0 idle, 1 seeding, 2 running, 3 finished.
  int       m_ph, m_gvt, m_cnt, m_eptr, m_dptr, m_senq, m_sdeq, m_maxq;
  bit [N-1:0] m_act;
  int       m_loc[N];
  bit       m_dseen;

  // Environment: event queue contents and per-core pending offers.
  logic [EW-1:0] pq[$];
  bit [N-1:0]    pend;
  logic [EW-1:0] pend_data[N];
  logic          s_enq, s_deq;
  logic [EW-1:0] s_ed;
  logic [N-1:0]  s_ack;
  int            k_gen, k_tmax;

  function automatic int min_idx();
    int b = 0;
    for (int i = 1; i < pq.size(); i++)
      if (pq[i][TW-1:0] < pq[b][TW-1:0]) b = i;
    return b;
  endfunction

  function automatic int first_from(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++)
      if (req[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.enq      = q_enq;
    a.enq_data = q_enq ? q_enq_data : '0;
    a.ack      = core_new_ack;
    a.deq      = q_deq;
    a.evt      = core_evt_vld;
    a.evt_data = (core_evt_vld != '0) ? core_evt_data : '0;
    a.busy     = busy;
    a.done     = done;
    a.gvt      = gvt;
    return a;
  endfunction

  task automatic clear_model();
    m_ph = 0; m_gvt = 0; m_cnt = 0; m_eptr = 0; m_dptr = 0; m_act = '0;
    m_dseen = 0; m_senq = 0; m_sdeq = 0; m_maxq = 0;
    for (int g = 0; g < N; g++) m_loc[g] = 0;
  endtask

  task automatic clear_env();
    pq.delete(); pend = '0; s_enq = 0; s_deq = 0; s_ack = '0; s_ed = '0;
  endtask

  // Predict this cycle's outputs from the present inputs, then advance the model.
  task automatic predict(output obs_t e);
    int   prev, cand, c;
    bit   has, drained;
    bit [N-1:0] nact;
    e = '0;
    prev   = m_ph;
    e.busy = (m_ph == 1) || (m_ph == 2);
    e.done = (m_ph == 3);
    e.gvt  = TW'(m_gvt);
    nact   = m_act & ~core_done;
    if (e.busy && (int'(q_count) > m_maxq)) m_maxq = int'(q_count);
    drained = (q_count == 0) && (m_act == 0) && (core_new_vld == 0);
    case (m_ph)
      0: if (start) begin
        m_ph = 1; m_gvt = 0; m_cnt = 0; nact = '0; m_senq = 0; m_sdeq = 0; m_maxq = 0;
      end
      1: if (!q_full) begin
        e.enq = 1; e.enq_data = {LPW'(m_cnt), TW'(0)};
        m_cnt++;
        if (m_cnt == NI) m_ph = 2;
      end
      2: begin
        has = 0; cand = 0;
        if (q_count != 0) begin has = 1; cand = int'(q_head[TW-1:0]); end
        for (int g = 0; g < N; g++)
          if (m_act[g] && (!has || m_loc[g] < cand)) begin cand = m_loc[g]; has = 1; end
        if (core_new_vld != 0 && !q_full) begin
          c = first_from(core_new_vld, m_eptr);
          e.ack[c] = 1; e.enq = 1; e.enq_data = core_new_data[c*EW +: EW];
          m_eptr = (c + 1) % N; m_senq++;
        end else if (q_count != 0 && core_ready != 0) begin
          c = first_from(core_ready, m_dptr);
          e.deq = 1; e.evt[c] = 1; e.evt_data = q_head;
          m_dptr = (c + 1) % N; m_loc[c] = int'(q_head[TW-1:0]); nact[c] = 1; m_sdeq++;
        end
        if (m_gvt > SE || (drained && m_dseen)) m_ph = 3;
        if (has && cand > m_gvt) m_gvt = cand;
      end
      default: m_ph = 0;
    endcase
    m_dseen = (prev == 2) && drained;
    m_act   = nact;
  endtask

  // One clock of stimulus: react to last cycle's DUT strobes, drive new inputs.
  task automatic step(input bit st, input bit ff);
    obs_t e;
    @(posedge clk); #1;
    if (s_deq && pq.size() > 0) pq.delete(min_idx());
    if (s_enq) pq.push_back(s_ed);
    for (int g = 0; g < N; g++) if (s_ack[g]) pend[g] = 0;
    for (int g = 0; g < N; g++)
      if (!pend[g] && $urandom_range(99) < k_gen) begin
        pend[g] = 1;
        pend_data[g] = {LPW'($urandom), TW'(m_gvt + $urandom_range(k_tmax))};
      end
    core_new_vld = pend;
    for (int g = 0; g < N; g++) core_new_data[g*EW +: EW] = pend_data[g];
    for (int g = 0; g < N; g++) begin
      core_ready[g] = ($urandom_range(99) < 70);
      core_done[g]  = ($urandom_range(99) < 25);
    end
    start   = st;
    q_count = CNTW'(pq.size());
    q_full  = ff || (pq.size() >= CAP);
    q_head  = (pq.size() > 0) ? pq[min_idx()] : EW'($urandom);
    predict(e);
    exp_q.push_back(e);
    @(negedge clk);
    s_enq = q_enq; s_ed = q_enq_data; s_deq = q_deq; s_ack = core_new_ack;
  endtask

  // Monitor: every presented output cycle is checked against the next expectation.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (!rst_n) exp_q.delete();
      else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        n_cmp++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_out t=%0t got enq=%b d=%h ack=%b deq=%b evt=%b ed=%h busy=%b done=%b gvt=%0d | want enq=%b d=%h ack=%b deq=%b evt=%b ed=%h busy=%b done=%b gvt=%0d",
                   $time, a.enq, a.enq_data, a.ack, a.deq, a.evt, a.evt_data, a.busy, a.done, a.gvt,
                   e.enq, e.enq_data, e.ack, e.deq, e.evt, e.evt_data, e.busy, e.done, e.gvt);
        end
      end
    end
  end

  task automatic check_reset(input string nm);
    logic [TW+4+2*N-1:0] v;
    v = {busy, done, gvt, q_enq, q_deq, core_new_ack, core_evt_vld};
    n_cmp++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL %s got busy=%b done=%b gvt=%0d enq=%b deq=%b ack=%b evt=%b want all zero",
               nm, busy, done, gvt, q_enq, q_deq, core_new_ack, core_evt_vld);
    end
  endtask

  task automatic check_stats();
`ifdef PDES_SCHED_STATS_EN
    n_cmp++;
    if (stat_enq !== 32'(m_senq) || stat_deq !== 32'(m_sdeq) || stat_maxq !== CNTW'(m_maxq)) begin
      n_fail++;
      $display("FAIL stats got enq=%0d deq=%0d maxq=%0d want enq=%0d deq=%0d maxq=%0d",
               stat_enq, stat_deq, stat_maxq, m_senq, m_sdeq, m_maxq);
    end
`endif
  endtask

  task automatic run_to_idle(input int budget);
    int k = 0;
    while (m_ph != 0 && k < budget) begin step(1'b0, 1'b0); k++; end
    n_cmp++;
    if (m_ph != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run_end got busy=%b after %0d cycles want busy=0 within budget", busy, k);
    end
  endtask

  task automatic do_run(input int tmax, input int gen, input int cycles);
    k_tmax = tmax; k_gen = gen;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < cycles; i++)
      step((m_ph == 2) && ($urandom_range(15) == 0), ($urandom_range(9) == 0));
    k_gen = 0;
    run_to_idle(3000);
    check_stats();
    clear_env();
    repeat (2) step(1'b0, 1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; core_new_vld = '0; core_new_data = '0; core_ready = '0;
    core_done = '0; q_head = '0; q_count = '0; q_full = 0;
    k_gen = 0; k_tmax = 1;
    clear_model(); clear_env();
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    rst_n = 1;
    repeat (2) step(1'b0, 1'b0);

    do_run(25, 35, 40);
    do_run(4, 20, 30);
    do_run(70, 40, 40);

    // Asynchronous reset in the middle of a run, then a fresh reseed.
    k_tmax = 20; k_gen = 30;
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    @(posedge clk); #3;
    rst_n = 0;
    #1 check_reset("async_mid_run");
    clear_model(); clear_env();
    start = 0; core_new_vld = '0; core_done = '0;
    @(negedge clk); #1;
    rst_n = 1;
    do_run(25, 30, 30);

    @(posedge clk); @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
